// File: rtl/retro_cart_pkg.sv
// Shared types for the retro cartridge bridge: region modes, region table entry and FSM states.
package retro_cart_pkg;

  localparam int CART_ADDR_W     = 16;
  localparam int CART_MEM_ADDR_W = 24;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_CART = 2'd1,
    MODE_ROM  = 2'd2,
    MODE_RAM  = 2'd3
  } region_mode_e;

  typedef struct packed {
    logic [CART_ADDR_W-1:0]     base;
    logic [CART_ADDR_W-1:0]     mask;
    logic [CART_MEM_ADDR_W-1:0] offset;
    region_mode_e               mode;
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CART_SU  = 3'd1,
    ST_CART_ST  = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/retro_cart_region_decode.sv
// Programmable region table plus priority match; lowest enabled matching index wins and
// its memory-port address is produced combinationally.
module retro_cart_region_decode
  import retro_cart_pkg::*;
#(
  parameter int  ADDR_W      = CART_ADDR_W,
  parameter int  MEM_ADDR_W  = CART_MEM_ADDR_W,
  parameter int  NUM_REGIONS = 4,
  localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  cfg_we_i,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic [ADDR_W-1:0]     cfg_base_i,
  input  logic [ADDR_W-1:0]     cfg_mask_i,
  input  logic [MEM_ADDR_W-1:0] cfg_offset_i,
  input  region_mode_e          cfg_mode_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o,
  output region_mode_e          mode_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o
);

  region_t region_q [NUM_REGIONS];

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!Reset) begin
        region_q[i] <= '0;
      end else if (cfg_we_i && (cfg_idx_i == IDX_W'(i))) begin
        region_q[i].base   <= cfg_base_i;
        region_q[i].mask   <= cfg_mask_i;
        region_q[i].offset <= cfg_offset_i;
        region_q[i].mode   <= cfg_mode_i;
      end
    end
  end

  // Walk from the top index down so the lowest matching index is the last one written.
  always_comb begin
    hit_o      = 1'b0;
    idx_o      = '0;
    mode_o     = MODE_OFF;
    mem_addr_o = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((region_q[i].mode != MODE_OFF) &&
          ((addr_i & region_q[i].mask) == region_q[i].base)) begin
        hit_o      = 1'b1;
        idx_o      = IDX_W'(i);
        mode_o     = region_q[i].mode;
        mem_addr_o = region_q[i].offset + MEM_ADDR_W'(addr_i & ~region_q[i].mask);
      end
    end
  end

endmodule

// File: rtl/retro_cart_bridge.sv
// GamePak bus bridge: decodes each core access to physical cart, memory ROM/RAM image or open bus
// and holds Delay high while the backing access runs.
module retro_cart_bridge
  import retro_cart_pkg::*;
#(
  parameter int                ADDR_W      = CART_ADDR_W,
  parameter int                DATA_W      = 8,
  parameter int                MEM_ADDR_W  = CART_MEM_ADDR_W,
  parameter int                NUM_REGIONS = 4,
  parameter int                CART_SETUP  = 2,
  parameter int                CART_STROBE = 4,
  parameter int                MEM_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] OPEN_BUS    = 'hFF,
  localparam int               IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ClkEn,
  input  logic                  Read,
  input  logic                  Write,
  input  logic                  CS,
  input  logic [ADDR_W-1:0]     Address,
  input  logic [DATA_W-1:0]     DataOut,
  output logic [DATA_W-1:0]     DataIn,
  output logic                  Delay,
  input  logic                  CfgWe,
  input  logic [IDX_W-1:0]      CfgIdx,
  input  logic [ADDR_W-1:0]     CfgBase,
  input  logic [ADDR_W-1:0]     CfgMask,
  input  logic [MEM_ADDR_W-1:0] CfgOffset,
  input  logic [1:0]            CfgMode,
  output logic [ADDR_W-1:0]     CartAddr,
  output logic [DATA_W-1:0]     CartDataOut,
  output logic                  CartDataOe,
  input  logic [DATA_W-1:0]     CartDataIn,
  output logic                  CartCS,
  output logic                  CartRead,
  output logic                  CartWrite,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [MEM_ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0]     MemWData,
  input  logic                  MemAck,
  input  logic                  MemRValid,
  input  logic [DATA_W-1:0]     MemRData,
  output logic                  ErrTimeout,
  output state_e                DbgState,
  output logic [IDX_W-1:0]      DbgRegion
);

  localparam int CNT_MAX0 = (CART_SETUP > CART_STROBE) ? CART_SETUP : CART_STROBE;
  localparam int CNT_MAX  = (MEM_TIMEOUT > CNT_MAX0) ? MEM_TIMEOUT : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  region_mode_e          dec_mode;
  logic [MEM_ADDR_W-1:0] dec_mem_addr;

  retro_cart_region_decode #(
    .ADDR_W      (ADDR_W),
    .MEM_ADDR_W  (MEM_ADDR_W),
    .NUM_REGIONS (NUM_REGIONS)
  ) u_decode (
    .Clk          (Clk),
    .Reset        (Reset),
    .cfg_we_i     (CfgWe),
    .cfg_idx_i    (CfgIdx),
    .cfg_base_i   (CfgBase),
    .cfg_mask_i   (CfgMask),
    .cfg_offset_i (CfgOffset),
    .cfg_mode_i   (region_mode_e'(CfgMode)),
    .addr_i       (Address),
    .hit_o        (dec_hit),
    .idx_o        (dec_idx),
    .mode_o       (dec_mode),
    .mem_addr_o   (dec_mem_addr)
  );

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic [IDX_W-1:0]      region_idx_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     data_in_q;
  logic                  delay_q;
  logic [ADDR_W-1:0]     cart_addr_q;
  logic [DATA_W-1:0]     cart_dout_q;
  logic                  cart_oe_q;
  logic                  cart_cs_q;
  logic                  cart_rd_q;
  logic                  cart_wr_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  err_q;

  logic accept;
  assign accept = ClkEn && CS && (Read || Write);

  // cnt_q times cart setup/strobe phases and, across MEM_REQ+MEM_WAIT, the memory timeout.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      region_idx_q <= '0;
      rdata_q      <= OPEN_BUS;
      data_in_q    <= OPEN_BUS;
      delay_q      <= 1'b0;
      cart_addr_q  <= '0;
      cart_dout_q  <= '0;
      cart_oe_q    <= 1'b0;
      cart_cs_q    <= 1'b0;
      cart_rd_q    <= 1'b0;
      cart_wr_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_q         <= Write;
            region_idx_q <= dec_idx;
            rdata_q      <= OPEN_BUS;
            delay_q      <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_DONE;
            case (dec_hit ? dec_mode : MODE_OFF)
              MODE_CART: begin
                state_q     <= ST_CART_SU;
                cart_addr_q <= Address;
                cart_dout_q <= DataOut;
                cart_oe_q   <= Write;
                cart_cs_q   <= 1'b1;
              end
              MODE_ROM: begin
                if (!Write) begin
                  state_q    <= ST_MEM_REQ;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= dec_mem_addr;
                end
              end
              MODE_RAM: begin
                state_q     <= ST_MEM_REQ;
                mem_req_q   <= 1'b1;
                mem_we_q    <= Write;
                mem_addr_q  <= dec_mem_addr;
                mem_wdata_q <= DataOut;
              end
              default: ;
            endcase
          end
        end
        ST_CART_SU: begin
          if (cnt_q == CNT_W'(CART_SETUP - 1)) begin
            state_q   <= ST_CART_ST;
            cnt_q     <= '0;
            cart_rd_q <= !wr_q;
            cart_wr_q <= wr_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CART_ST: begin
          if (cnt_q == CNT_W'(CART_STROBE - 1)) begin
            state_q   <= ST_DONE;
            cart_cs_q <= 1'b0;
            cart_rd_q <= 1'b0;
            cart_wr_q <= 1'b0;
            cart_oe_q <= 1'b0;
            if (!wr_q) rdata_q <= CartDataIn;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_MEM_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (MemAck) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= wr_q ? ST_DONE : ST_MEM_WAIT;
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_MEM_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (MemRValid) begin
            rdata_q <= MemRData;
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          delay_q <= 1'b0;
          if (!wr_q) data_in_q <= rdata_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DataIn      = data_in_q;
  assign Delay       = delay_q;
  assign CartAddr    = cart_addr_q;
  assign CartDataOut = cart_dout_q;
  assign CartDataOe  = cart_oe_q;
  assign CartCS      = cart_cs_q;
  assign CartRead    = cart_rd_q;
  assign CartWrite   = cart_wr_q;
  assign MemReq      = mem_req_q;
  assign MemWe       = mem_we_q;
  assign MemAddr     = mem_addr_q;
  assign MemWData    = mem_wdata_q;
  assign ErrTimeout  = err_q;
  assign DbgState    = state_q;
  assign DbgRegion   = region_idx_q;

endmodule

// File: tb/tb_retro_cart_bridge.sv
// Scenario bench for retro_cart_bridge: scripted core accesses, a simple memory responder and a
// read-data scoreboard.
module tb_retro_cart_bridge;
  import retro_cart_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, ClkEn, Read, Write, CS;
  logic [15:0] Address;
  logic [7:0]  DataOut, DataIn;
  logic        Delay;
  logic        CfgWe;
  logic [1:0]  CfgIdx;
  logic [15:0] CfgBase, CfgMask;
  logic [23:0] CfgOffset;
  logic [1:0]  CfgMode;
  logic [15:0] CartAddr;
  logic [7:0]  CartDataOut, CartDataIn;
  logic        CartDataOe, CartCS, CartRead, CartWrite;
  logic        MemReq, MemWe, MemAck, MemRValid;
  logic [23:0] MemAddr;
  logic [7:0]  MemWData, MemRData;
  logic        ErrTimeout;
  state_e      DbgState;
  logic [1:0]  DbgRegion;

  retro_cart_bridge #(.MEM_TIMEOUT(8)) dut (
    .Clk(Clk), .Reset(Reset), .ClkEn(ClkEn), .Read(Read), .Write(Write), .CS(CS),
    .Address(Address), .DataOut(DataOut), .DataIn(DataIn), .Delay(Delay),
    .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgBase(CfgBase), .CfgMask(CfgMask),
    .CfgOffset(CfgOffset), .CfgMode(CfgMode),
    .CartAddr(CartAddr), .CartDataOut(CartDataOut), .CartDataOe(CartDataOe),
    .CartDataIn(CartDataIn), .CartCS(CartCS), .CartRead(CartRead), .CartWrite(CartWrite),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRValid(MemRValid), .MemRData(MemRData),
    .ErrTimeout(ErrTimeout), .DbgState(DbgState), .DbgRegion(DbgRegion)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_din;

  // per-access observations and responder settings
  int          delay_cyc, cs_cyc, rd_cyc, wr_cyc, oe_cyc, req_cyc;
  logic [23:0] seen_mem_addr;
  logic        seen_mem_we;
  logic [7:0]  seen_mem_wdata, seen_cart_dout;
  logic [15:0] seen_cart_addr;
  int          ack_dly, rv_dly, reset_at;
  logic [7:0]  mem_rdata;
  bit          cfg_mid;

  task automatic cfg(input int idx, input logic [15:0] base, input logic [15:0] mask,
                     input logic [23:0] off, input logic [1:0] mode);
    @(negedge Clk);
    CfgWe = 1'b1; CfgIdx = 2'(idx); CfgBase = base; CfgMask = mask;
    CfgOffset = off; CfgMode = mode;
    @(negedge Clk);
    CfgWe = 1'b0;
  endtask

  task automatic access(input string tag, input bit wr, input logic [15:0] a,
                        input logic [7:0] wd);
    int   guard;
    int   wait_cyc;
    bit   acked;
    logic [7:0] e;
    delay_cyc = 0; cs_cyc = 0; rd_cyc = 0; wr_cyc = 0; oe_cyc = 0; req_cyc = 0;
    seen_mem_addr = '0; seen_mem_we = 1'b0; seen_mem_wdata = '0;
    seen_cart_addr = '0; seen_cart_dout = '0;
    guard = 0; wait_cyc = 0; acked = 1'b0;
    @(negedge Clk);
    Address = a; DataOut = wd; Read = !wr; Write = wr; CS = 1'b1;
    @(negedge Clk);
    CS = 1'b0; Read = 1'b0; Write = 1'b0;
    while (Delay === 1'b1 && guard < 200) begin
      guard++;
      delay_cyc++;
      if (CartCS) begin
        if (cs_cyc == 0) begin seen_cart_addr = CartAddr; seen_cart_dout = CartDataOut; end
        cs_cyc++;
      end
      if (CartRead) rd_cyc++;
      if (CartWrite) wr_cyc++;
      if (CartDataOe) oe_cyc++;
      if (acked) wait_cyc++;
      MemRValid = acked && rv_dly > 0 && wait_cyc == rv_dly;
      MemRData  = MemRValid ? mem_rdata : 8'h00;
      if (MemReq) begin
        if (req_cyc == 0) begin
          seen_mem_addr = MemAddr; seen_mem_we = MemWe; seen_mem_wdata = MemWData;
        end
        req_cyc++;
      end
      MemAck = MemReq && ack_dly >= 0 && (req_cyc - 1) == ack_dly;
      if (MemAck) acked = 1'b1;
      CfgWe = cfg_mid && delay_cyc == 2;
      if (delay_cyc == reset_at) Reset = 1'b0;
      @(negedge Clk);
    end
    MemAck = 1'b0; MemRValid = 1'b0; CfgWe = 1'b0;
    n_vec++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL %s_delay_bound: Delay still %b after %0d cycles, required low", tag, Delay, guard);
    end
    if (!wr && reset_at < 0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s_scoreboard: no expected read data queued", tag);
      end else begin
        e = exp_q.pop_front();
        model_din = e;
        if (DataIn !== e) begin
          n_err++;
          $display("FAIL %s_datain: got %h want %h", tag, DataIn, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    n_vec++;
    if ({DataIn, Delay, CartCS, CartRead, CartWrite, CartDataOe, MemReq, MemWe, ErrTimeout} !==
        {8'hFF, 8'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got DataIn=%h Delay=%b CS=%b MemReq=%b Err=%b want FF/0/0/0/0",
               DataIn, Delay, CartCS, MemReq, ErrTimeout);
    end
    n_vec++;
    if (DbgState !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", DbgState, ST_IDLE);
    end
    Reset = 1'b1;
    // request without ClkEn must be ignored
    @(negedge Clk);
    ClkEn = 1'b0; CS = 1'b1; Read = 1'b1; Address = 16'h1234;
    @(negedge Clk);
    CS = 1'b0; Read = 1'b0; ClkEn = 1'b1;
    n_vec++;
    if (Delay !== 1'b0) begin
      n_err++; $display("FAIL clken_gate: Delay got %b want 0", Delay);
    end
    exp_q.push_back(8'hFF);
    access("reset_read", 1'b0, 16'h1234, 8'h00);
    n_vec++;
    if (delay_cyc !== 1) begin
      n_err++; $display("FAIL reset_read_delay: got %0d want 1", delay_cyc);
    end
    n_vec++;
    if (cs_cyc + rd_cyc + wr_cyc + req_cyc !== 0) begin
      n_err++; $display("FAIL reset_read_strobes: got %0d strobe cycles want 0",
                        cs_cyc + rd_cyc + wr_cyc + req_cyc);
    end
  endtask

  task automatic test_cart();
    cfg(0, 16'h0000, 16'h8000, 24'h0, 2'd1);
    CartDataIn = 8'h5A;
    exp_q.push_back(8'h5A);
    access("cart_read", 1'b0, 16'h0123, 8'h00);
    n_vec++;
    if ({cs_cyc, rd_cyc, wr_cyc, oe_cyc, delay_cyc} !== {32'd6, 32'd4, 32'd0, 32'd0, 32'd7}) begin
      n_err++;
      $display("FAIL cart_read_timing: got cs=%0d rd=%0d wr=%0d oe=%0d dly=%0d want 6/4/0/0/7",
               cs_cyc, rd_cyc, wr_cyc, oe_cyc, delay_cyc);
    end
    n_vec++;
    if (seen_cart_addr !== 16'h0123) begin
      n_err++; $display("FAIL cart_read_addr: got %h want 0123", seen_cart_addr);
    end
    access("cart_write", 1'b1, 16'h0456, 8'hC3);
    n_vec++;
    if ({cs_cyc, rd_cyc, wr_cyc, oe_cyc} !== {32'd6, 32'd0, 32'd4, 32'd6}) begin
      n_err++;
      $display("FAIL cart_write_timing: got cs=%0d rd=%0d wr=%0d oe=%0d want 6/0/4/6",
               cs_cyc, rd_cyc, wr_cyc, oe_cyc);
    end
    n_vec++;
    if ({seen_cart_addr, seen_cart_dout, DataIn} !== {16'h0456, 8'hC3, model_din}) begin
      n_err++;
      $display("FAIL cart_write_data: got addr=%h dout=%h din=%h want 0456/c3/%h",
               seen_cart_addr, seen_cart_dout, DataIn, model_din);
    end
  endtask

  task automatic test_mem_ram();
    cfg(1, 16'hA000, 16'hE000, 24'hFFFFF0, 2'd3);
    ack_dly = 3; rv_dly = -1;
    access("ram_write", 1'b1, 16'hA020, 8'h77);
    n_vec++;
    if ({seen_mem_addr, seen_mem_we, seen_mem_wdata} !== {24'h000010, 1'b1, 8'h77}) begin
      n_err++;
      $display("FAIL ram_write_req: got addr=%h we=%b wd=%h want 000010/1/77",
               seen_mem_addr, seen_mem_we, seen_mem_wdata);
    end
    n_vec++;
    if ({req_cyc, delay_cyc} !== {32'd4, 32'd5}) begin
      n_err++; $display("FAIL ram_write_hold: got req=%0d dly=%0d want 4/5", req_cyc, delay_cyc);
    end
    ack_dly = 0; rv_dly = 2; mem_rdata = 8'h3C;
    exp_q.push_back(8'h3C);
    access("ram_read", 1'b0, 16'hA021, 8'h00);
    n_vec++;
    if ({seen_mem_addr, seen_mem_we, delay_cyc} !== {24'h000011, 1'b0, 32'd4}) begin
      n_err++;
      $display("FAIL ram_read_req: got addr=%h we=%b dly=%0d want 000011/0/4",
               seen_mem_addr, seen_mem_we, delay_cyc);
    end
  endtask

  task automatic test_mem_rom();
    cfg(1, 16'hA000, 16'hE000, 24'h000100, 2'd2);
    ack_dly = 0; rv_dly = 5; mem_rdata = 8'hE7;
    access("rom_write", 1'b1, 16'hA005, 8'h55);
    n_vec++;
    if ({req_cyc, delay_cyc, DataIn} !== {32'd0, 32'd1, model_din}) begin
      n_err++;
      $display("FAIL rom_write_drop: got req=%0d dly=%0d din=%h want 0/1/%h",
               req_cyc, delay_cyc, DataIn, model_din);
    end
    exp_q.push_back(8'hE7);
    access("rom_read", 1'b0, 16'hA005, 8'h00);
    n_vec++;
    if ({seen_mem_addr, req_cyc, delay_cyc} !== {24'h000105, 32'd1, 32'd7}) begin
      n_err++;
      $display("FAIL rom_read_req: got addr=%h req=%0d dly=%0d want 000105/1/7",
               seen_mem_addr, req_cyc, delay_cyc);
    end
  endtask

  task automatic test_overlap();
    cfg(2, 16'h4000, 16'hC000, 24'h002000, 2'd3);
    CfgIdx = 2'd0; CfgMode = 2'd0; CfgBase = 16'h0; CfgMask = 16'h0; CfgOffset = 24'h0;
    cfg_mid = 1'b1;
    CartDataIn = 8'h11;
    exp_q.push_back(8'h11);
    access("overlap_first", 1'b0, 16'h4000, 8'h00);
    cfg_mid = 1'b0;
    n_vec++;
    if ({cs_cyc, req_cyc, 30'(DbgRegion)} !== {32'd6, 32'd0, 30'd0}) begin
      n_err++;
      $display("FAIL overlap_priority: got cs=%0d req=%0d region=%0d want 6/0/0",
               cs_cyc, req_cyc, DbgRegion);
    end
    ack_dly = 0; rv_dly = 1; mem_rdata = 8'h99;
    exp_q.push_back(8'h99);
    access("overlap_after", 1'b0, 16'h4000, 8'h00);
    n_vec++;
    if ({cs_cyc, req_cyc, seen_mem_addr, 30'(DbgRegion)} !== {32'd0, 32'd1, 24'h002000, 30'd2}) begin
      n_err++;
      $display("FAIL overlap_reprogram: got cs=%0d req=%0d addr=%h region=%0d want 0/1/002000/2",
               cs_cyc, req_cyc, seen_mem_addr, DbgRegion);
    end
  endtask

  task automatic test_random_rom();
    logic [15:0] a;
    logic [23:0] off;
    logic [23:0] ea;
    logic [7:0]  d;
    off = 24'($urandom_range(0, 24'hFFFFFF));
    cfg(3, 16'hC000, 16'hC000, off, 2'd2);
    for (int i = 0; i < 6; i++) begin
      a = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
      d = 8'($urandom_range(0, 255));
      ack_dly = $urandom_range(0, 3);
      rv_dly  = $urandom_range(1, 3);
      mem_rdata = d;
      ea = off + {8'h00, a & 16'h3FFF};
      exp_q.push_back(d);
      access("rand_rom", 1'b0, a, 8'h00);
      n_vec++;
      if (seen_mem_addr !== ea || delay_cyc !== ack_dly + rv_dly + 2) begin
        n_err++;
        $display("FAIL rand_rom_req: got addr=%h dly=%0d want %h/%0d",
                 seen_mem_addr, delay_cyc, ea, ack_dly + rv_dly + 2);
      end
    end
  endtask

  task automatic test_timeout();
    ack_dly = -1; rv_dly = -1;
    exp_q.push_back(8'hFF);
    access("timeout_req", 1'b0, 16'hA010, 8'h00);
    n_vec++;
    if ({req_cyc, delay_cyc, ErrTimeout} !== {32'd8, 32'd9, 1'b1}) begin
      n_err++;
      $display("FAIL timeout_req: got req=%0d dly=%0d err=%b want 8/9/1", req_cyc, delay_cyc, ErrTimeout);
    end
    ack_dly = 0; rv_dly = -1; reset_at = 3;
    access("reset_mid_wait", 1'b0, 16'hA010, 8'h00);
    reset_at = -1;
    n_vec++;
    if ({MemReq, Delay, ErrTimeout, DataIn} !== {3'b000, 8'hFF} || DbgState !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_mid_wait: got req=%b dly=%b err=%b din=%h st=%0d want 0/0/0/ff/0",
               MemReq, Delay, ErrTimeout, DataIn, DbgState);
    end
    Reset = 1'b1;
    ack_dly = 0; rv_dly = 1; mem_rdata = 8'h00;
    exp_q.push_back(8'hFF);
    access("table_cleared", 1'b0, 16'hA010, 8'h00);
    n_vec++;
    if ({req_cyc, delay_cyc} !== {32'd0, 32'd1}) begin
      n_err++; $display("FAIL table_cleared: got req=%0d dly=%0d want 0/1", req_cyc, delay_cyc);
    end
  endtask

  initial begin
    Reset = 1'b0; ClkEn = 1'b1; Read = 1'b0; Write = 1'b0; CS = 1'b0;
    Address = '0; DataOut = '0; CfgWe = 1'b0; CfgIdx = '0; CfgBase = '0; CfgMask = '0;
    CfgOffset = '0; CfgMode = '0; CartDataIn = '0; MemAck = 1'b0; MemRValid = 1'b0;
    MemRData = '0; ack_dly = 0; rv_dly = 1; reset_at = -1; mem_rdata = '0; cfg_mid = 1'b0;
    model_din = 8'hFF;
    test_reset();
    test_cart();
    test_mem_ram();
    test_mem_rom();
    test_overlap();
    test_random_rom();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
